or1200_qmem_arbiter: RTL and testbench

//  Two-master, one-slave arbiter between the OR1200 QMEM instruction and data ports and one shared memory port.

---
 rtl/or1200_qmem_arbiter.sv | 128 ++++++++++++
 tb/tb_or1200_qmem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_qmem_arbiter.sv
// Two-master (OR1200 QMEM data/instruction) to one-slave memory arbiter with a bounded slave timeout.
// Define OR1200_QMEM_ARB_DPRIO_EN for fixed data-master priority; otherwise round-robin on simultaneous requests.
module or1200_qmem_arbiter #(
    parameter int AW   = 24,
    parameter int TO_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dcpu_cs,
    input  logic          dcpu_we,
    input  logic [3:0]    dcpu_sel,
    input  logic [AW-1:0] dcpu_adr,
    input  logic [31:0]   dcpu_dat_w,
    output logic [31:0]   dcpu_dat_r,
    output logic          dcpu_ack,
    input  logic          icpu_cs,
    input  logic [AW-1:0] icpu_adr,
    output logic [31:0]   icpu_dat_r,
    output logic          icpu_ack,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [3:0]    mem_sel,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_dat_w,
    input  logic [31:0]   mem_dat_r,
    input  logic          mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_t;

    // Timeout fires on the cycle whose increment would bring tcnt to all-ones.
    localparam logic [TO_W-1:0] TCNT_FIRE = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] TCNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic            last_i_q, last_i_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;

    logic            pick_d;
    logic            is_d;
    logic            x_cs;
    logic            x_ack;
    logic [31:0]     x_dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_i_q <= 1'b1;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_i_q <= last_i_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_i_d   = last_i_q;
        tcnt_d     = tcnt_q;
        pick_d     = 1'b0;
        is_d       = 1'b0;
        x_cs       = 1'b0;
        x_ack      = 1'b0;
        x_dat      = 32'h0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 4'h0;
        mem_adr    = '0;
        mem_dat_w  = 32'h0;
        dcpu_ack   = 1'b0;
        icpu_ack   = 1'b0;
        dcpu_dat_r = 32'h0;
        icpu_dat_r = 32'h0;

        if (state_q == IDLE) begin
            tcnt_d = '0;
`ifdef OR1200_QMEM_ARB_DPRIO_EN
            pick_d = dcpu_cs;
`else
            pick_d = dcpu_cs & (~icpu_cs | last_i_q);
`endif
            if (dcpu_cs || icpu_cs) begin
                state_d  = pick_d ? BUSY_D : BUSY_I;
                last_i_d = ~pick_d;
            end
        end else begin
            is_d  = (state_q == BUSY_D);
            x_cs  = is_d ? dcpu_cs : icpu_cs;
            x_ack = mem_ack & x_cs;
            x_dat = mem_dat_r;

            mem_cs = x_cs;
            if (is_d) begin
                mem_we    = dcpu_we;
                mem_sel   = dcpu_sel;
                mem_adr   = dcpu_adr;
                mem_dat_w = dcpu_dat_w;
            end else begin
                mem_sel   = 4'hF;
                mem_adr   = icpu_adr;
            end

            // A dropped cs aborts; a real ack beats a same-cycle timeout.
            if (!x_cs || mem_ack) begin
                state_d = IDLE;
            end else if (tcnt_q == TCNT_FIRE) begin
                x_ack   = 1'b1;
                x_dat   = 32'hFFFF_FFFF;
                mem_cs  = 1'b0;
                tcnt_d  = tcnt_q + TCNT_ONE;
                state_d = IDLE;
            end else begin
                tcnt_d  = tcnt_q + TCNT_ONE;
            end

            dcpu_ack   = is_d & x_ack;
            icpu_ack   = ~is_d & x_ack;
            dcpu_dat_r = is_d ? x_dat : mem_dat_r;
            icpu_dat_r = is_d ? mem_dat_r : x_dat;
        end
    end

endmodule

// File: tb/tb_or1200_qmem_arbiter.sv
// Randomized self-checking bench for or1200_qmem_arbiter against a transaction-level reference model.
module tb_or1200_qmem_arbiter;

    localparam int AW     = 24;
    localparam int TO_W   = 4;
    localparam int TO_CYC = (1 << TO_W) - 1;

    logic          clk;
    logic          rst;
    logic          dcpu_cs, dcpu_we;
    logic [3:0]    dcpu_sel;
    logic [AW-1:0] dcpu_adr;
    logic [31:0]   dcpu_dat_w, dcpu_dat_r;
    logic          dcpu_ack;
    logic          icpu_cs;
    logic [AW-1:0] icpu_adr;
    logic [31:0]   icpu_dat_r;
    logic          icpu_ack;
    logic          mem_cs, mem_we;
    logic [3:0]    mem_sel;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_dat_w, mem_dat_r;
    logic          mem_ack;

    or1200_qmem_arbiter #(.AW(AW), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .dcpu_cs(dcpu_cs), .dcpu_we(dcpu_we), .dcpu_sel(dcpu_sel), .dcpu_adr(dcpu_adr),
        .dcpu_dat_w(dcpu_dat_w), .dcpu_dat_r(dcpu_dat_r), .dcpu_ack(dcpu_ack),
        .icpu_cs(icpu_cs), .icpu_adr(icpu_adr), .icpu_dat_r(icpu_dat_r), .icpu_ack(icpu_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_sel(mem_sel), .mem_adr(mem_adr),
        .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: 1 when the instruction master holds the last grant.
    bit            last_i = 1'b1;
    logic [AW-1:0] d_adr, i_adr;
    logic          d_we;
    logic [3:0]    d_sel;
    logic [31:0]   d_datw;
    bit            use_fix = 1'b0;
    logic [31:0]   fix_dat = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_grant_d(input bit rd, input bit ri);
        bit g;
        if (rd && ri) begin
`ifdef OR1200_QMEM_ARB_DPRIO_EN
            g = 1'b1;
`else
            g = last_i;
`endif
        end else begin
            g = rd;
        end
        last_i = !g;
        return g;
    endfunction

    // One full transfer: IDLE request cycle, then busy cycles until ack, timeout or abort.
    task automatic xfer(input bit rd, input bit ri, input int lat, input int abort_at);
        bit          gd;
        bit          done;
        logic [31:0] md, exp_dat;
        logic        exp_cs, exp_ack;
        gd = model_grant_d(rd, ri);
        @(negedge clk);
        dcpu_cs = rd; icpu_cs = ri;
        dcpu_adr = d_adr; dcpu_we = d_we; dcpu_sel = d_sel; dcpu_dat_w = d_datw;
        icpu_adr = i_adr; mem_ack = 1'b0; mem_dat_r = $urandom;
        #2;
        check("idle_mem_cs", mem_cs, 0);
        check("idle_acks", {dcpu_ack, icpu_ack}, 0);
        done = 1'b0;
        for (int k = 1; k <= TO_CYC + 2 && !done; k++) begin
            @(negedge clk);
            mem_dat_r = use_fix ? fix_dat : $urandom;
            md = mem_dat_r;
            if (k == abort_at) begin
                if (gd) dcpu_cs = 1'b0; else icpu_cs = 1'b0;
                mem_ack = 1'b1;
                #2;
                check("abort_mem_cs", mem_cs, 0);
                check("abort_acks", {dcpu_ack, icpu_ack}, 0);
                @(negedge clk);
                dcpu_cs = 1'b0; icpu_cs = 1'b0;
                #2;
                check("late_ack", {dcpu_ack, icpu_ack}, 0);
                check("late_mem_cs", mem_cs, 0);
                mem_ack = 1'b0;
                done = 1'b1;
            end else begin
                mem_ack = (k == lat);
                #2;
                check("mem_adr", mem_adr, gd ? d_adr : i_adr);
                check("mem_we", mem_we, gd ? d_we : 1'b0);
                check("mem_sel", mem_sel, gd ? d_sel : 4'hF);
                check("mem_dat_w", mem_dat_w, gd ? d_datw : 32'h0);
                exp_dat = 32'h0;
                if (k == lat) begin
                    exp_cs = 1'b1; exp_ack = 1'b1; exp_dat = md;
                end else if (k == TO_CYC) begin
                    exp_cs = 1'b0; exp_ack = 1'b1; exp_dat = 32'hFFFF_FFFF;
                end else begin
                    exp_cs = 1'b1; exp_ack = 1'b0;
                end
                check("mem_cs", mem_cs, exp_cs);
                check(gd ? "d_ack" : "i_ack", gd ? dcpu_ack : icpu_ack, exp_ack);
                check("other_ack", gd ? icpu_ack : dcpu_ack, 0);
                if (exp_ack) begin
                    check("dat_r", gd ? dcpu_dat_r : icpu_dat_r, exp_dat);
                    done = 1'b1;
                end
            end
        end
        check("xfer_done", done, 1);
    endtask

    task automatic rand_fields();
        d_adr  = AW'($urandom);
        i_adr  = AW'($urandom);
        d_we   = 1'($urandom);
        d_sel  = 4'($urandom);
        d_datw = $urandom;
    endtask

    initial begin
        bit gd;
        rst = 1'b1;
        dcpu_cs = 1'b1; icpu_cs = 1'b1; dcpu_we = 1'b0; dcpu_sel = 4'h0;
        dcpu_adr = '0; dcpu_dat_w = 32'h0; icpu_adr = '0;
        mem_ack = 1'b0; mem_dat_r = 32'hA5A5_A5A5;
        #1 rst = 1'b0;

        repeat (3) begin
            @(negedge clk);
            #2;
            check("rst_mem_cs", mem_cs, 0);
            check("rst_acks", {dcpu_ack, icpu_ack}, 0);
            check("rst_dat_r", dcpu_dat_r | icpu_dat_r, 0);
            check("rst_mem_adr", mem_adr, 0);
            check("rst_mem_sel", mem_sel, 0);
        end
        @(negedge clk);
        rst = 1'b1; dcpu_cs = 1'b0; icpu_cs = 1'b0;

        rand_fields();
        xfer(1, 1, 2, 0);

        i_adr = 24'h000100; use_fix = 1'b1; fix_dat = 32'h1234_5678;
        xfer(0, 1, 2, 0);
        use_fix = 1'b0;

        d_adr = 24'h00FFFC; d_we = 1'b1; d_sel = 4'b0011; d_datw = 32'hCAFE_BABE;
        xfer(1, 0, 3, 0);

        xfer(1, 0, 100, 0);
        xfer(0, 1, TO_CYC, 0);

        xfer(0, 1, 5, 1);
        rand_fields();
        xfer(1, 0, 1, 0);

        d_adr = 24'h111111; i_adr = 24'h222222;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dcpu_cs = 1'b1; icpu_cs = 1'b1; mem_ack = 1'b1;
            dcpu_adr = d_adr; icpu_adr = i_adr; dcpu_we = 1'b0;
            #2;
            if (i % 2 == 0) begin
                check("cont_idle_cs", mem_cs, 0);
            end else begin
                gd = model_grant_d(1, 1);
                check("cont_cs", mem_cs, 1);
                check("cont_adr", mem_adr, gd ? d_adr : i_adr);
                check("cont_ack", {dcpu_ack, icpu_ack}, gd ? 2'b10 : 2'b01);
            end
        end

        rand_fields();
        @(negedge clk);
        dcpu_cs = 1'b1; icpu_cs = 1'b0; mem_ack = 1'b0; dcpu_adr = d_adr;
        gd = model_grant_d(1, 0);
        @(negedge clk);
        #2;
        check("pre_rst_cs", mem_cs, 1);
        #1 mem_ack = 1'b1; rst = 1'b0;
        #1;
        check("mid_rst_cs", mem_cs, 0);
        check("mid_rst_ack", {dcpu_ack, icpu_ack}, 0);
        check("mid_rst_dat", dcpu_dat_r, 0);
        @(negedge clk);
        rst = 1'b1; dcpu_cs = 1'b0; mem_ack = 1'b0;
        last_i = 1'b1;

        repeat (60) begin
            int r, lat, ab;
            r   = $urandom_range(1, 3);
            lat = $urandom_range(1, 18);
            ab  = 0;
            if (($urandom % 5) == 0 && lat > 1)
                ab = $urandom_range(1, (lat - 1 < 14) ? lat - 1 : 14);
            rand_fields();
            xfer(r[0], r[1], lat, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
